// File: rtl/stall_controller_gen.sv
// stall_controller_gen: per-channel IDLE/RUN/DRAIN clock-gating stall controller with latch-based glitch-free gates.
// Define STALL_CTRL_DRAIN_EN to keep each gated clock running DRAIN_CYCLES extra pulses after finish.
module stall_controller_gen #(
    parameter int N_CH         = 8,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N_CH-1:0] ch_en,
    input  logic [N_CH-1:0] finish,
    input  logic            global_finish,
    output logic [N_CH-1:0] gated_clk,
    output logic [N_CH-1:0] active,
    output logic            busy,
    output logic            done
);

    if (DRAIN_CYCLES < 1 || CNT_W < $clog2(DRAIN_CYCLES + 1)) begin : g_bad_cfg
        $error("stall_controller_gen: DRAIN_CYCLES must be >= 1 and fit in CNT_W bits");
    end

`ifdef STALL_CTRL_DRAIN_EN
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif

    state_t          state_q [N_CH];
    state_t          state_d [N_CH];
    logic [N_CH-1:0] active_q;
    logic [N_CH-1:0] active_d;
    logic [N_CH-1:0] en_lat;
    logic            done_q;
    logic            done_d;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
`ifdef STALL_CTRL_DRAIN_EN
            cnt_d[i] = cnt_q[i];
`endif
            case (state_q[i])
                IDLE: if (start && ch_en[i] && !global_finish) state_d[i] = RUN;
`ifdef STALL_CTRL_DRAIN_EN
                RUN: if (finish[i] || global_finish) begin
                    state_d[i] = DRAIN;
                    cnt_d[i]   = CNT_W'(DRAIN_CYCLES);
                end
                DRAIN: begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                    if (cnt_q[i] == CNT_W'(1)) state_d[i] = IDLE;
                end
`else
                RUN: if (finish[i] || global_finish) state_d[i] = IDLE;
`endif
                default: state_d[i] = IDLE;
            endcase
            active_d[i] = state_d[i] != IDLE;
        end
    end

    // done fires on the same edge busy falls, so it is high in the cycle right after it
    assign busy   = |active_q;
    assign done_d = busy & ~(|active_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
`ifdef STALL_CTRL_DRAIN_EN
                cnt_q[i] <= '0;
`endif
            end
            active_q <= '0;
            done_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
`ifdef STALL_CTRL_DRAIN_EN
                cnt_q[i] <= cnt_d[i];
`endif
            end
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Latch only opens while clk is low, so enable changes never reach the AND during a high phase
    always_latch begin
        if (!rst) en_lat = '0;
        else if (!clk) en_lat = active_q;
    end

    assign gated_clk = {N_CH{clk}} & en_lat;
    assign active    = active_q;
    assign done      = done_q;

endmodule

// File: tb/tb_stall_controller_gen.sv
// tb_stall_controller_gen: directed checks of start masking, drain/no-drain timing, contention and async reset.
module tb_stall_controller_gen;

`ifdef STALL_CTRL_DRAIN_EN
    localparam int DR = 2;
`else
    localparam int DR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] ch_en = '0;
    logic [7:0] finish = '0;
    logic       global_finish = 1'b0;
    logic [7:0] gated_clk;
    logic [7:0] active;
    logic       busy;
    logic       done;
    int         nvec = 0;
    int         nerr = 0;

    stall_controller_gen #(.N_CH(8), .DRAIN_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_en(ch_en), .finish(finish),
        .global_finish(global_finish), .gated_clk(gated_clk), .active(active),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] gc, input logic [7:0] act, input logic dn);
        chk({tag, ".gated_clk"}, gated_clk, gc);
        chk({tag, ".active"}, active, act);
        chk({tag, ".busy"}, busy, |act);
        chk({tag, ".done"}, done, dn);
    endtask

    // Call right after the finish edge has been sampled; m are the only running channels
    task automatic drain_seq(input string tag, input logic [7:0] m);
        for (int k = 0; k <= DR + 1; k++) begin
            if (k > 0) tick();
            chk_all($sformatf("%s.k%0d", tag, k), (k <= DR) ? m : 8'h00, (k < DR) ? m : 8'h00, k == DR);
        end
    endtask

    initial begin
        start = 1'b1;
        ch_en = 8'hFF;
        repeat (3) tick();
        chk_all("reset_hold", 8'h00, 8'h00, 1'b0);
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) tick();
        chk_all("reset_release", 8'h00, 8'h00, 1'b0);

        ch_en = 8'h05;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("start_edge", 8'h00, 8'h05, 1'b0);
        tick();
        chk_all("first_pulse", 8'h05, 8'h05, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("start_in_run", 8'h05, 8'h05, 1'b0);

        finish = 8'h02;
        tick();
        finish = 8'h00;
        chk_all("finish_in_idle", 8'h05, 8'h05, 1'b0);

        finish = 8'h01;
        tick();
        finish = 8'h00;
        chk_all("fin0.k0", 8'h05, (DR > 0) ? 8'h05 : 8'h04, 1'b0);
        if (DR > 0) start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            start = 1'b0;
            chk_all($sformatf("fin0.k%0d", k), (k <= DR) ? 8'h05 : 8'h04, (k < DR) ? 8'h05 : 8'h04, 1'b0);
        end

        finish = 8'h04;
        tick();
        finish = 8'h00;
        drain_seq("fin2_last", 8'h04);

        ch_en         = 8'hFF;
        start         = 1'b1;
        global_finish = 1'b1;
        tick();
        start         = 1'b0;
        global_finish = 1'b0;
        chk_all("start_vs_gfin", 8'h00, 8'h00, 1'b0);
        tick();
        chk_all("start_vs_gfin2", 8'h00, 8'h00, 1'b0);

        ch_en = 8'h30;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("start_30", 8'h00, 8'h30, 1'b0);
        tick();
        global_finish = 1'b1;
        tick();
        global_finish = 1'b0;
        drain_seq("gfin", 8'h30);

        ch_en = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_all("run_all", 8'hFF, 8'hFF, 1'b0);
        rst = 1'b0;
        #1;
        chk_all("async_rst_high", 8'h00, 8'h00, 1'b0);
        tick();
        chk_all("async_rst_next", 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        tick();
        chk_all("after_rst", 8'h00, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/stall_controller_gen.md
# stall_controller_gen

Parametrised per-layer clock-gating stall controller for the SqueezeNext accelerator pipeline, generalising the fixed eight-layer controllers to `N_CH` channels. Each channel runs its own IDLE/RUN/DRAIN state machine, which:
- starts its layer when the upstream layer signals completion and the channel's flag is set,
- gates that layer's clock with a glitch-free latch-based gate,
- keeps the clock running for a programmable drain window after finish, so in-flight pipeline data retires.

The block sits between the layer-completion logic and the per-layer clock trees.

## Interface
Parameters:
- `N_CH`, 8, number of gated layer clocks.
- `DRAIN_CYCLES`, 2, extra gated clock pulses after a channel finishes; must be ≥1.
- `CNT_W`, 4, drain counter width; must be ≥ clog2(`DRAIN_CYCLES`+1).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  upstream layer finished (temp_zero of previous layer); level, sampled on rising `clk`.
- `ch_en`  in  `N_CH`  per-channel enable flags; a channel starts only if its bit is 1 when `start` is sampled.
- `finish`  in  `N_CH`  per-channel layer-finished indication.
- `global_finish`  in  1  finish for all channels at once (finish_layer).
- `gated_clk`  out  `N_CH`  gated clock per channel.
- `active`  out  `N_CH`  channel state ≠ IDLE (registered).
- `busy`  out  1  OR of `active`.
- `done`  out  1  one-cycle pulse when `busy` falls.

## Operation
Per-channel FSM (state, counter), all updated on rising `clk`:
- **IDLE → RUN:** when `start` && `ch_en[i]` && !`global_finish`.
- **IDLE, otherwise:** stays IDLE.
  - `finish[i]` is ignored in IDLE.
  - `global_finish` dominates `start` when both are present in the same cycle.
- **RUN → DRAIN:** on `finish[i]` || `global_finish`; counter loads `DRAIN_CYCLES`.
- **RUN:** `start` is ignored.
- **DRAIN:** decrement the counter each cycle.
  - At counter==1, go to IDLE.
  - `start`, `finish` and `global_finish` are ignored in DRAIN; there is no restart until IDLE is reached.

Outputs:
- Gate enable `en[i]` = state ≠ IDLE.
- `gated_clk[i]` = `clk` AND `en_lat[i]`. `en_lat[i]` is a latch that is transparent while `clk` is low and holds while `clk` is high, so there are no glitches or truncated pulses.
- `active` and `busy` are derived from the registered state.
- `done` is a registered pulse, asserted for one cycle after the edge where `busy` goes 1→0.

Reset (`rst` low, asynchronous):
- All states IDLE, counters 0, `en_lat` 0.
- `gated_clk` 0, `active` 0, `busy` 0, `done` 0.
- Reset asserted mid-RUN or mid-DRAIN kills the gated clock immediately with no drain.
- Reset release is synchronous to the next rising `clk` and carries no pending start.

## Timing
- `start` sampled at edge t → state RUN after t → `en_lat` opens in the low phase → first `gated_clk[i]` rising edge coincides with `clk` edge t+1.
- `finish[i]` sampled at edge t (state RUN):
  - The pulse at edge t has already occurred.
  - With drain: pulses at t+1 … t+`DRAIN_CYCLES`, IDLE after edge t+`DRAIN_CYCLES`, no pulse at t+`DRAIN_CYCLES`+1.
  - Without drain: IDLE after t, no pulse at t+1.
- `done` is high in the cycle after the last channel reaches IDLE.
- Channels are fully independent; simultaneous transitions on any subset are allowed.

## Configuration
- `STALL_CTRL_DRAIN_EN` defined: DRAIN state and counter are present, and behaviour is as above.
- Not defined: no DRAIN state and no counter.
  - RUN → IDLE directly on `finish[i]` || `global_finish`.
  - `DRAIN_CYCLES` and `CNT_W` are ignored.

## Test plan
- **Reset:** hold `rst`=0 with `start`=1, `ch_en`=8'hFF → all `gated_clk`, `active`, `busy` and `done` are 0. Release `rst` → no pulse until `start` is sampled.
- **Start mask:** `ch_en`=8'b0000_0101, `start` pulsed at edge 5 → `active`=8'h05 after edge 5; `gated_clk[0]` and `gated_clk[2]` first rise at edge 6; other channels stay 0.
- **Drain (macro on, `DRAIN_CYCLES`=2):** `finish[0]` at edge 20 → `gated_clk[0]` pulses at edges 21 and 22, none at 23. `active[0]` is 0 after edge 22; `done` is high in cycle 23 if channel 0 was the last active channel.
- **No drain (macro off):** same stimulus as the drain scenario → last pulse at edge 20, `active[0]` is 0 after edge 20, `done` is high in the following cycle.
- **Contention:** `start` and `global_finish` in the same cycle while all channels are IDLE → stay IDLE. `finish[i]` while IDLE → ignored. `start` during RUN/DRAIN → no restart.
- **Async reset mid-RUN:** `rst` falls while `clk` is high → `gated_clk` goes to 0 immediately with no drain pulses, `done` stays 0.
